// File: rtl/fp_pkg.sv
// Shared GF(p) arithmetic definitions: default field parameters, operation codes and helpers.
package fp_pkg;

  localparam int unsigned W_DEFAULT    = 255;
  localparam int unsigned LIMB_DEFAULT = 64;

  // SQISign prime 5*2^248 - 1
  localparam logic [254:0] P_SQISIGN = (255'd5 << 248) - 255'd1;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned m);
    return (n + m - 1) / m;
  endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Valid/ready operand and result channel of the pipelined modular add/sub unit.
interface fp_addsub_pipe_if
  import fp_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     d;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, op, a, b, tag_in, out_ready,
    input  in_ready, out_valid, d, tag_out
  );

  modport slave (
    input  in_valid, op, a, b, tag_in, out_ready,
    output in_ready, out_valid, d, tag_out
  );

endinterface

// File: rtl/fp_limb_stage.sv
// One registered limb of the dual (raw / corrected) carry chains.
// Limbs below K hold finished results; limbs from K upward still hold unprocessed operands.
module fp_limb_stage
  import fp_pkg::*;
#(
  parameter int unsigned          LIMB  = 64,
  parameter int unsigned          NL    = 4,
  parameter int unsigned          K     = 0,
  parameter int unsigned          TAG_W = 4,
  parameter logic [NL*LIMB-1:0]   P     = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_in,
  input  op_t                  op_in,
  input  logic [NL*LIMB-1:0]   s_in,
  input  logic [NL*LIMB-1:0]   u_in,
  input  logic                 c_s_in,
  input  logic                 c_u_in,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 valid_out,
  output op_t                  op_out,
  output logic [NL*LIMB-1:0]   s_out,
  output logic [NL*LIMB-1:0]   u_out,
  output logic                 c_s_out,
  output logic                 c_u_out,
  output logic [TAG_W-1:0]     tag_out
);

  logic [LIMB-1:0]    p_limb;
  logic [LIMB:0]      s_sum;
  logic [LIMB:0]      u_sum;
  logic [NL*LIMB-1:0] s_d;
  logic [NL*LIMB-1:0] u_d;

  // s carries operand a in its upper limbs, u carries the conditioned operand b
  always_comb begin
    p_limb = (op_in == OP_SUB) ? P[K*LIMB +: LIMB] : ~P[K*LIMB +: LIMB];
    s_sum  = {1'b0, s_in[K*LIMB +: LIMB]} + {1'b0, u_in[K*LIMB +: LIMB]}
             + {{LIMB{1'b0}}, c_s_in};
    u_sum  = {1'b0, s_sum[LIMB-1:0]} + {1'b0, p_limb} + {{LIMB{1'b0}}, c_u_in};
    s_d    = s_in;
    u_d    = u_in;
    s_d[K*LIMB +: LIMB] = s_sum[LIMB-1:0];
    u_d[K*LIMB +: LIMB] = u_sum[LIMB-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      op_out    <= OP_ADD;
      s_out     <= '0;
      u_out     <= '0;
      c_s_out   <= 1'b0;
      c_u_out   <= 1'b0;
      tag_out   <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      op_out    <= op_in;
      s_out     <= s_d;
      u_out     <= u_d;
      c_s_out   <= s_sum[LIMB];
      c_u_out   <= u_sum[LIMB];
      tag_out   <= tag_in;
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Fully pipelined modular add/subtract over GF(P): one carry-chain limb per stage, then a
// registered select between raw and corrected sums. Whole pipeline stalls on output backpressure.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned  W     = W_DEFAULT,
  parameter int unsigned  LIMB  = LIMB_DEFAULT,
  parameter logic [W-1:0] P     = W'(P_SQISIGN),
  parameter int unsigned  TAG_W = 4
) (
  input logic             clk,
  input logic             rst,
  fp_addsub_pipe_if.slave io
);

  localparam int unsigned   NL      = ceil_div(W, LIMB);
  localparam int unsigned   WP      = NL * LIMB;
  localparam int unsigned   LATENCY = NL + 1;
  localparam logic [WP-1:0] P_PAD   = WP'(P);

  // Index k is the input of limb stage k; index NL feeds the select stage.
  logic             v   [LATENCY];
  op_t              o   [LATENCY];
  logic [WP-1:0]    s   [LATENCY];
  logic [WP-1:0]    u   [LATENCY];
  logic             c_s [LATENCY];
  logic             c_u [LATENCY];
  logic [TAG_W-1:0] t   [LATENCY];

  logic             in_ready;
  logic             out_valid_q;
  logic [W-1:0]     d_q;
  logic [TAG_W-1:0] tag_q;
  logic             sel_u;
  logic [W-1:0]     res;

  assign in_ready = !out_valid_q || io.out_ready;

  // Sub is a + ~b + 1, corrected by +P; add is a + b, corrected by + ~P + 1 (i.e. -P).
  assign v[0]   = io.in_valid && in_ready;
  assign o[0]   = io.op;
  assign s[0]   = WP'(io.a);
  assign u[0]   = (io.op == OP_SUB) ? ~(WP'(io.b)) : WP'(io.b);
  assign c_s[0] = (io.op == OP_SUB);
  assign c_u[0] = (io.op == OP_ADD);
  assign t[0]   = io.tag_in;

  for (genvar k = 0; k < NL; k++) begin : g_stage
    fp_limb_stage #(
      .LIMB  (LIMB),
      .NL    (NL),
      .K     (k),
      .TAG_W (TAG_W),
      .P     (P_PAD)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (in_ready),
      .valid_in  (v[k]),
      .op_in     (o[k]),
      .s_in      (s[k]),
      .u_in      (u[k]),
      .c_s_in    (c_s[k]),
      .c_u_in    (c_u[k]),
      .tag_in    (t[k]),
      .valid_out (v[k+1]),
      .op_out    (o[k+1]),
      .s_out     (s[k+1]),
      .u_out     (u[k+1]),
      .c_s_out   (c_s[k+1]),
      .c_u_out   (c_u[k+1]),
      .tag_out   (t[k+1])
    );
  end

  // Add: take s-P unless it borrowed. Sub: take s+P when a-b borrowed.
  always_comb begin
    sel_u = 1'b0;
    if (o[NL] == OP_SUB) begin
      sel_u = !c_s[NL];
    end else begin
      sel_u = c_s[NL] || c_u[NL];
    end
    res = sel_u ? u[NL][W-1:0] : s[NL][W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      tag_q       <= '0;
    end else if (in_ready) begin
      out_valid_q <= v[NL];
      d_q         <= res;
      tag_q       <= t[NL];
    end
  end

  if (WP > W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{s[NL][WP-1:W], u[NL][WP-1:W]};
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.d         = d_q;
  assign io.tag_out   = tag_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed and streaming checks of fp_addsub_pipe: reset, wrap cases, mixed ops, stall, reset.
module tb_fp_addsub_pipe;
  import fp_pkg::*;

  localparam int unsigned   W     = 255;
  localparam int unsigned   TAG_W = 4;
  localparam int            LAT   = 5;
  localparam logic [W-1:0]  P     = (255'd5 << 248) - 255'd1;

  typedef struct packed {
    logic [W-1:0]     d;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

  fp_addsub_pipe #(
    .W     (W),
    .LIMB  (64),
    .P     (P),
    .TAG_W (TAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  exp_t             q[$];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_errors = 0;
  bit               lat_chk = 1'b1;
  bit               prev_stall = 1'b0;
  logic [W-1:0]     prev_d;
  logic [TAG_W-1:0] prev_tag;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input op_t op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0] r;
    if (op == OP_ADD) begin
      r = {1'b0, a} + {1'b0, b};
      if (r >= {1'b0, P}) r = r - {1'b0, P};
    end else if (a >= b) begin
      r = {1'b0, a} - {1'b0, b};
    end else begin
      r = {1'b0, a} + {1'b0, P} - {1'b0, b};
    end
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return W'(r[249:0]);  // below 2^250 < P, so already reduced
  endfunction

  // Drive one cycle at the falling edge; score the handshakes of the coming rising edge.
  task automatic cycle(input logic iv, input op_t op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TAG_W-1:0] tag, input logic ordy,
                       input logic [W-1:0] exp_d, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.tag_in    = tag;
    bus.out_ready = ordy;
    #1;
    cyc++;
    if (prev_stall) begin
      check("hold_d", 256'(bus.d), 256'(prev_d));
      check("hold_tag", 256'(bus.tag_out), 256'(prev_tag));
    end
    if (bus.out_valid && !ordy) check("in_ready_stall", 256'(bus.in_ready), 256'(0));
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        check("spurious_out", 256'(bus.out_valid), 256'(0));
      end else begin
        e = q.pop_front();
        check("d", 256'(bus.d), 256'(e.d));
        check("tag", 256'(bus.tag_out), 256'(e.tag));
        if (lat_chk) check("latency", 256'(cyc - e.cyc), 256'(LAT));
      end
    end
    prev_stall = bus.out_valid && !ordy;
    prev_d     = bus.d;
    prev_tag   = bus.tag_out;
    acc        = iv && bus.in_ready;
    if (acc) q.push_back('{d: exp_d, tag: tag, cyc: cyc});
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      cycle(1'b0, OP_ADD, '0, '0, '0, 1'b1, '0, acc);
      n++;
    end
    check("drain_empty", 256'(q.size()), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit           acc;
    bit           ordy;
    int           i;
    int           k;
    op_t          op;
    logic [W-1:0] ra [16];
    logic [W-1:0] rb [16];

    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.a         = 255'd7;
    bus.b         = 255'd9;
    bus.tag_in    = 4'd1;
    bus.out_ready = 1'b1;

    // Reset held with input offered: nothing may come out
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_out_valid", 256'(bus.out_valid), 256'(0));
      check("rst_d", 256'(bus.d), 256'(0));
      check("rst_tag", 256'(bus.tag_out), 256'(0));
      check("rst_in_ready", 256'(bus.in_ready), 256'(1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;

    // Directed wrap and no-correction cases
    cycle(1'b1, OP_SUB, 255'd0, 255'd1, 4'd3, 1'b1, P - 255'd1, acc);
    cycle(1'b1, OP_ADD, P - 255'd1, 255'd1, 4'd4, 1'b1, 255'd0, acc);
    cycle(1'b1, OP_ADD, P - 255'd1, P - 255'd1, 4'd5, 1'b1, P - 255'd2, acc);
    cycle(1'b1, OP_ADD, 255'd1 << 200, 255'd1 << 200, 4'd6, 1'b1, 255'd1 << 201, acc);
    cycle(1'b1, OP_SUB, 255'd5, 255'd3, 4'd7, 1'b1, 255'd2, acc);
    cycle(1'b1, OP_SUB, P - 255'd1, 255'd0, 4'd8, 1'b1, P - 255'd1, acc);
    cycle(1'b1, OP_SUB, 255'd3, 255'd5, 4'd9, 1'b1, P - 255'd2, acc);
    cycle(1'b1, OP_ADD, 255'd0, 255'd0, 4'd10, 1'b1, 255'd0, acc);
    drain();

    for (int j = 0; j < 16; j++) begin
      ra[j] = (j % 5 == 0) ? P - 255'(j) - 255'd1 : rnd();
      rb[j] = (j % 7 == 3) ? P - 255'd1 : rnd();
    end

    // Back-to-back mixed ops: every beat must emerge exactly LAT cycles later
    for (int j = 0; j < 16; j++) begin
      op = op_t'(j[0]);
      cycle(1'b1, op, ra[j], rb[j], 4'(j), 1'b1, model(op, ra[j], rb[j]), acc);
      check("stream_accept", 256'(acc), 256'(1));
    end
    drain();

    // Streaming with a 3-cycle output stall; input retries until accepted
    lat_chk = 1'b0;
    i = 0;
    k = 0;
    while (i < 16 && k < 100) begin
      ordy = !(k >= 7 && k <= 9);
      op = op_t'(~i[0]);
      cycle(1'b1, op, rb[i], ra[i], 4'(15 - i), ordy, model(op, rb[i], ra[i]), acc);
      if (acc) i++;
      k++;
    end
    check("bp_all_sent", 256'(i), 256'(16));
    drain();

    // Reset with a valid result at the output and more beats behind it
    lat_chk = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, OP_ADD, ra[j], rb[j], 4'(j), 1'b1, model(OP_ADD, ra[j], rb[j]), acc);
    end
    @(negedge clk);
    check("pre_rst_valid", 256'(bus.out_valid), 256'(1));
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 256'(bus.out_valid), 256'(0));
    check("midrst_d", 256'(bus.d), 256'(0));
    check("midrst_tag", 256'(bus.tag_out), 256'(0));
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      cycle(1'b0, OP_ADD, '0, '0, '0, 1'b1, '0, acc);
      check("post_rst_idle", 256'(bus.out_valid), 256'(0));
    end
    cycle(1'b1, OP_SUB, 255'd100, 255'd58, 4'd12, 1'b1, 255'd42, acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined modular add/subtract unit over GF(p) for the SQISign datapath.
- Successor to the fixed-function subtractor. Adds:
  - a per-operation add/sub mode;
  - configurable operand width and limb size, with one carry-chain limb per pipeline stage;
  - valid/ready flow control with global stall;
  - a transaction tag that travels alongside each result.
- One result per cycle when not stalled.

Parameters:
- W, 255, operand width in bits.
- LIMB, 64, bits per carry-chain stage. NL = ceil(W/LIMB) limbs.
- P, 5*2^248-1 (W bits), prime modulus. Requires P < 2^W.
- TAG_W, 4, tag width.
- LATENCY, NL+1 (derived localparam; not overridable). Cycles from input accept to output valid.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts the beat this cycle.
- op  in  1  0 = add (a+b mod P), 1 = sub (a-b mod P).
- a  in  W  operand, must be < P.
- b  in  W  operand, must be < P.
- tag_in  in  TAG_W  user tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- d  out  W  result, always in [0, P).
- tag_out  out  TAG_W  tag of this result.

Behaviour:
- Reset (rst=0, asynchronous): every stage valid bit clears, out_valid=0, d=0, tag_out=0. in_ready follows its equation below, so it reads 1 during reset.
- Reset mid-operation discards all in-flight beats; no partial results are emitted after reset release.
- Accept: a beat is accepted when in_valid && in_ready.
- Advance/stall: in_ready = !out_valid || out_ready. The whole pipeline advances only when in_ready=1; otherwise every stage holds its value, including d and tag_out.
- Bubbles are not collapsed. If a beat is not accepted in an advancing cycle, stage 0 loads valid=0.
- Stage k (0..NL-1) processes limb k. Limbs above the current stage are carried forward unprocessed (skewed).
  - Raw result s: a+b for add; a-b for sub (as a+~b+1).
  - Correction u, computed in parallel from s limbs: s-P for add; s+P for sub.
  - Two carry/borrow bits, c_s and c_u, are registered per stage.
- Final stage NL (select):
  - add: d = u if (c_s_out || !borrow_u), else s.
  - sub: d = u if a borrow occurred (i.e. !c_s_out), else s.
- Every result is truncated to W bits. Inputs >= P give an unspecified d, but valid/tag sequencing remains correct.
- Throughput: 1 beat/cycle when out_ready is held at 1. Accepted order equals output order.
- Occupancy is at most LATENCY beats, with no internal FIFO.
- Same-cycle accept and output fire is legal and is the steady state.
- If out_ready drops while out_valid=1, d/tag_out are held stable until the handshake completes. Upstream sees in_ready=0 in that same cycle (combinational).

Decomposition:
- Shared package fp_pkg holds:
  - constants: default W, P_SQISIGN (5*2^248-1), LIMB;
  - a function ceil_div;
  - an enum op_t {OP_ADD=0, OP_SUB=1}.
  - fp_add/fp_sub and later mul units import it.
- One natural sub-module, fp_limb_stage:
  - one registered limb of dual carry chains, with enable and valid, instantiated NL times via generate.
  - The select stage stays in the top module.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> out_valid=0, d=0 throughout. After release, first out_valid appears exactly LATENCY (=5) cycles after the first accept.
- Sub wrap: a=0, b=1, op=1, tag=3 -> d=P-1=0x4FF…FE (62 F's, last F→E), tag_out=3.
- Add wrap: a=P-1, b=1, op=0 -> d=0. Also a=P-1, b=P-1 -> d=P-2. Also a=2^200, b=2^200 -> d=2^201 (no correction).
- Streaming mixed ops: alternate op=0/1 each cycle on 16 random reduced pairs with tags 0..15, out_ready=1. Results must match the (a±b) mod P model, in order, one per cycle, no gaps.
- Backpressure: during streaming, drop out_ready for 3 cycles -> in_ready=0 in those cycles, d/tag_out stable, no beat lost or duplicated. Resume must be in order.
- Mid-flight reset: assert rst=0 with 3 beats in flight -> outputs clear immediately. No stale beat appears after release. The next accepted beat returns after LATENCY cycles.
